rob_mc: RTL and testbench

- Multi-channel reorder buffer, parametrised successor to the single-channel ROB.
- Accepts tagged read requests from a client and routes each to one of NCH memory channels by an address field.
- Channels may return data out of order.
- Returns data to the client strictly in request order, with full rsp_ready backpressure and per-channel mem_req_ready flow control.

---
 rtl/rob_mc.sv | 219 +++++++++++++++++++++
 tb/tb_rob_mc.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mc.sv
// Multi-channel reorder buffer: routes tagged reads to NCH channels and returns data in order.
// Optional statistics outputs are enabled with the ROB_MC_STATS_EN macro.
module rob_mc #(
  parameter int unsigned SWIDTH    = 4,
  parameter int unsigned NCH       = 2,
  parameter int unsigned CWIDTH    = 1,
  parameter int unsigned CHSEL_LSB = 2,
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned PWIDTH    = 10,
  parameter int unsigned IDWIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     req_val,
  input  logic [AWIDTH-1:0]        req_addr,
  input  logic [IDWIDTH-1:0]       req_ID,
  input  logic [PWIDTH-1:0]        req_param,
  output logic                     req_ready,
  output logic                     rsp_val,
  output logic [DWIDTH-1:0]        rsp_data,
  output logic [IDWIDTH-1:0]       rsp_ID,
  output logic [PWIDTH-1:0]        rsp_param,
  input  logic                     rsp_ready,
  output logic [NCH-1:0]           mem_req_val,
  output logic [NCH*AWIDTH-1:0]    mem_req_addr,
  output logic [NCH*SWIDTH-1:0]    mem_req_ID,
  input  logic [NCH-1:0]           mem_req_ready,
  input  logic [NCH-1:0]           mem_rsp_val,
  input  logic [NCH*SWIDTH-1:0]    mem_rsp_ID,
  input  logic [NCH*DWIDTH-1:0]    mem_rsp_data,
  output logic                     err_spurious
`ifdef ROB_MC_STATS_EN
  ,
  output logic [SWIDTH:0]          occupancy,
  output logic [SWIDTH:0]          peak_occupancy,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned DEPTH = 2**SWIDTH;
  localparam logic [SWIDTH:0] DepthC = DEPTH[SWIDTH:0];

  typedef enum logic [1:0] {StFree, StIssued, StDone} ent_st_e;

  ent_st_e            st_q    [DEPTH];
  ent_st_e            st_d    [DEPTH];
  logic [CWIDTH-1:0]  ech_q   [DEPTH];
  logic [CWIDTH-1:0]  ech_d   [DEPTH];
  logic [DWIDTH-1:0]  data_q  [DEPTH];
  logic [DWIDTH-1:0]  data_d  [DEPTH];
  logic [IDWIDTH-1:0] id_q    [DEPTH];
  logic [IDWIDTH-1:0] id_d    [DEPTH];
  logic [PWIDTH-1:0]  param_q [DEPTH];
  logic [PWIDTH-1:0]  param_d [DEPTH];
  logic [DEPTH-1:0]   hand_q, hand_d;
  logic [DEPTH-1:0]   claim;

  logic [AWIDTH-1:0]  oaddr_q [NCH];
  logic [AWIDTH-1:0]  oaddr_d [NCH];
  logic [SWIDTH-1:0]  otag_q  [NCH];
  logic [SWIDTH-1:0]  otag_d  [NCH];
  logic [NCH-1:0]     oval_q, oval_d;

  logic [SWIDTH-1:0]  head_q, head_d, tail_q, tail_d, rtag;
  logic [SWIDTH:0]    count_q, count_d;
  logic               err_q, err_d;
  logic [31:0]        ch_int;
  logic [CWIDTH-1:0]  ch_sel;
  logic               accept, retire;

  always_comb begin
    ch_int = 32'(req_addr[CHSEL_LSB +: CWIDTH]) % NCH;
    ch_sel = ch_int[CWIDTH-1:0];
  end

  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready = !rst_ && (count_q != DepthC) && (!oval_q[ch_sel] || mem_req_ready[ch_sel]);
  assign accept    = req_val && req_ready;
  assign rsp_val   = (st_q[head_q] == StDone);
  assign retire    = rsp_val && rsp_ready;

  always_comb begin
    st_d    = st_q;
    ech_d   = ech_q;
    data_d  = data_q;
    id_d    = id_q;
    param_d = param_q;
    hand_d  = hand_q;
    oval_d  = oval_q;
    oaddr_d = oaddr_q;
    otag_d  = otag_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    claim   = '0;
    rtag    = '0;

    for (int c = 0; c < NCH; c++) begin
      if (oval_q[c] && mem_req_ready[c]) begin
        oval_d[c]         = 1'b0;
        hand_d[otag_q[c]] = 1'b1;
      end
    end

    // Lower channels are evaluated first, so they win when two name the same tag.
    for (int c = 0; c < NCH; c++) begin
      if (mem_rsp_val[c]) begin
        rtag = mem_rsp_ID[c*SWIDTH +: SWIDTH];
        if (st_q[rtag] == StIssued && ech_q[rtag] == CWIDTH'(c) && hand_q[rtag] &&
            !claim[rtag]) begin
          claim[rtag]  = 1'b1;
          st_d[rtag]   = StDone;
          data_d[rtag] = mem_rsp_data[c*DWIDTH +: DWIDTH];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (retire) begin
      st_d[head_q] = StFree;
      head_d       = head_q + SWIDTH'(1);
    end

    if (accept) begin
      st_d[tail_q]    = StIssued;
      hand_d[tail_q]  = 1'b0;
      ech_d[tail_q]   = ch_sel;
      id_d[tail_q]    = req_ID;
      param_d[tail_q] = req_param;
      oval_d[ch_sel]  = 1'b1;
      oaddr_d[ch_sel] = req_addr;
      otag_d[ch_sel]  = tail_q;
      tail_d          = tail_q + SWIDTH'(1);
    end

    count_d = count_q + {{SWIDTH{1'b0}}, accept} - {{SWIDTH{1'b0}}, retire};
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]    <= StFree;
        ech_q[i]   <= '0;
        data_q[i]  <= '0;
        id_q[i]    <= '0;
        param_q[i] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        oaddr_q[c] <= '0;
        otag_q[c]  <= '0;
      end
      hand_q  <= '0;
      oval_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      ech_q   <= ech_d;
      data_q  <= data_d;
      id_q    <= id_d;
      param_q <= param_d;
      oaddr_q <= oaddr_d;
      otag_q  <= otag_d;
      hand_q  <= hand_d;
      oval_q  <= oval_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_req_addr = '0;
    mem_req_ID   = '0;
    for (int c = 0; c < NCH; c++) begin
      mem_req_addr[c*AWIDTH +: AWIDTH] = oaddr_q[c];
      mem_req_ID[c*SWIDTH +: SWIDTH]   = otag_q[c];
    end
  end

  assign mem_req_val  = oval_q;
  assign rsp_data     = data_q[head_q];
  assign rsp_ID       = id_q[head_q];
  assign rsp_param    = param_q[head_q];
  assign err_spurious = err_q;

`ifdef ROB_MC_STATS_EN
  logic [SWIDTH:0] peak_q, peak_d;
  logic [31:0]     stall_q, stall_d;

  always_comb begin
    peak_d  = (count_d > peak_q) ? count_d : peak_q;
    stall_d = stall_q;
    if (req_val && !req_ready && !(&stall_q)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      peak_q  <= peak_d;
      stall_q <= stall_d;
    end
  end

  assign occupancy      = count_q;
  assign peak_occupancy = peak_q;
  assign stall_cycles   = stall_q;
`endif

endmodule

// File: tb/tb_rob_mc.sv
// Self-checking bench for rob_mc: directed scenarios plus randomized traffic against a
// transaction-level scoreboard of outstanding requests.
module tb_rob_mc;
  localparam int SW = 4, NCH = 2, CW = 1, CL = 2, AW = 32, DW = 32, PW = 10, IW = 16;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              req_val;
  logic [AW-1:0]     req_addr;
  logic [IW-1:0]     req_ID;
  logic [PW-1:0]     req_param;
  logic              req_ready;
  logic              rsp_val;
  logic [DW-1:0]     rsp_data;
  logic [IW-1:0]     rsp_ID;
  logic [PW-1:0]     rsp_param;
  logic              rsp_ready;
  logic [NCH-1:0]    mem_req_val;
  logic [NCH*AW-1:0] mem_req_addr;
  logic [NCH*SW-1:0] mem_req_ID;
  logic [NCH-1:0]    mem_req_ready;
  logic [NCH-1:0]    mem_rsp_val;
  logic [NCH*SW-1:0] mem_rsp_ID;
  logic [NCH*DW-1:0] mem_rsp_data;
  logic              err_spurious;

  always #5 clk = ~clk;

  rob_mc #(.SWIDTH(SW), .NCH(NCH), .CWIDTH(CW), .CHSEL_LSB(CL), .AWIDTH(AW), .DWIDTH(DW),
           .PWIDTH(PW), .IDWIDTH(IW)) dut (
    .clk(clk), .rst_(rst_), .req_val(req_val), .req_addr(req_addr), .req_ID(req_ID),
    .req_param(req_param), .req_ready(req_ready), .rsp_val(rsp_val), .rsp_data(rsp_data),
    .rsp_ID(rsp_ID), .rsp_param(rsp_param), .rsp_ready(rsp_ready), .mem_req_val(mem_req_val),
    .mem_req_addr(mem_req_addr), .mem_req_ID(mem_req_ID), .mem_req_ready(mem_req_ready),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_ID(mem_rsp_ID), .mem_rsp_data(mem_rsp_data),
    .err_spurious(err_spurious)
  );

  // Scoreboard: outstanding tags in request order plus per-tag bookkeeping.
  int            order[$];
  int            mem_out[$];   // handed-off requests awaiting a response: ch*DEPTH + tag
  bit            e_handed [DEPTH];
  bit            e_done   [DEPTH];
  int            e_ch     [DEPTH];
  logic [AW-1:0] e_addr   [DEPTH];
  logic [IW-1:0] e_id     [DEPTH];
  logic [PW-1:0] e_param  [DEPTH];
  logic [DW-1:0] e_data   [DEPTH];
  bit            pend_v   [NCH];
  int            pend_tag [NCH];
  int            next_tag;
  bit            m_err;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_of(input logic [AW-1:0] a);
    return int'((a >> CL) & ((1 << CW) - 1)) % NCH;
  endfunction

  function automatic bit present(input int t);
    foreach (order[k]) if (order[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_ready();
    int ch;
    ch = chan_of(req_addr);
    return (order.size() < DEPTH) && (!pend_v[ch] || mem_req_ready[ch]);
  endfunction

  task automatic model_reset();
    order.delete();
    mem_out.delete();
    for (int c = 0; c < NCH; c++) pend_v[c] = 1'b0;
    next_tag = 0;
    m_err    = 1'b0;
  endtask

  task automatic cmp_all();
    bit ev;
    chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready()});
    ev = (order.size() > 0) && e_done[order[0]];
    chk("rsp_val", {63'd0, rsp_val}, {63'd0, ev});
    if (ev) begin
      chk("rsp_data", 64'(rsp_data), 64'(e_data[order[0]]));
      chk("rsp_ID", 64'(rsp_ID), 64'(e_id[order[0]]));
      chk("rsp_param", 64'(rsp_param), 64'(e_param[order[0]]));
    end
    for (int c = 0; c < NCH; c++) begin
      chk("mem_req_val", {63'd0, mem_req_val[c]}, {63'd0, pend_v[c]});
      if (pend_v[c]) begin
        chk("mem_req_addr", 64'(mem_req_addr[c*AW +: AW]), 64'(e_addr[pend_tag[c]]));
        chk("mem_req_ID", 64'(mem_req_ID[c*SW +: SW]), 64'(pend_tag[c]));
      end
    end
    chk("err_spurious", {63'd0, err_spurious}, {63'd0, m_err});
  endtask

  task automatic model_step();
    bit do_ret, do_acc;
    int ch, t;
    do_ret = (order.size() > 0) && e_done[order[0]] && rsp_ready;
    do_acc = req_val && exp_ready();
    ch     = chan_of(req_addr);
    for (int c = 0; c < NCH; c++) begin
      if (mem_rsp_val[c]) begin
        t = int'(mem_rsp_ID[c*SW +: SW]);
        if (present(t) && !e_done[t] && e_ch[t] == c && e_handed[t]) begin
          e_done[t] = 1'b1;
          e_data[t] = mem_rsp_data[c*DW +: DW];
        end else begin
          m_err = 1'b1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (pend_v[c] && mem_req_ready[c]) begin
        e_handed[pend_tag[c]] = 1'b1;
        mem_out.push_back(c * DEPTH + pend_tag[c]);
        pend_v[c] = 1'b0;
      end
    end
    if (do_acc) begin
      t = next_tag;
      e_handed[t] = 1'b0;
      e_done[t]   = 1'b0;
      e_ch[t]     = ch;
      e_addr[t]   = req_addr;
      e_id[t]     = req_ID;
      e_param[t]  = req_param;
      order.push_back(t);
      pend_v[ch]   = 1'b1;
      pend_tag[ch] = t;
      next_tag     = (next_tag + 1) % DEPTH;
    end
    if (do_ret) void'(order.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_val       = 1'b0;
    req_addr      = '0;
    req_ID        = '0;
    req_param     = '0;
    rsp_ready     = 1'b0;
    mem_req_ready = '1;
    mem_rsp_val   = '0;
    mem_rsp_ID    = '0;
    mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    idle();
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_val", {63'd0, rsp_val}, 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_ID", 64'(rsp_ID), 64'd0);
    chk("rst_rsp_param", 64'(rsp_param), 64'd0);
    chk("rst_mem_req_val", 64'(mem_req_val), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_mem_req_ID", 64'(mem_req_ID), 64'd0);
    chk("rst_err", {63'd0, err_spurious}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
    model_reset();
  endtask

  task automatic req(input int addr, input int id, input int param);
    req_val   = 1'b1;
    req_addr  = AW'(addr);
    req_ID    = IW'(id);
    req_param = PW'(param);
  endtask

  task automatic resp(input int c, input int tag, input logic [DW-1:0] data);
    mem_rsp_val[c]            = 1'b1;
    mem_rsp_ID[c*SW +: SW]    = SW'(tag);
    mem_rsp_data[c*DW +: DW]  = data;
  endtask

  initial begin
    bit used [NCH];
    int k, c, t;
    #2;

    // In-order responses, channel alternates with address bit 2.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req(4 * i, i, i);
      tick();
      chk("t1_issue_val", {63'd0, mem_req_val[i % 2]}, 64'd1);
      chk("t1_issue_tag", 64'(mem_req_ID[(i % 2)*SW +: SW]), 64'(i));
    end
    req_val = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_rsp_val = '0;
      resp(i % 2, i, 32'hA000 + i);
      tick();
      chk("t1_rsp_val", {63'd0, rsp_val}, 64'd1);
      chk("t1_rsp_ID", 64'(rsp_ID), 64'(i));
      chk("t1_rsp_data", 64'(rsp_data), 64'(32'hA000 + i));
    end
    mem_rsp_val = '0;
    tick();
    chk("t1_drain", {63'd0, rsp_val}, 64'd0);

    // Reverse-order responses: nothing retires until tag 0 returns.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req(4 * i, i, i);
      tick();
    end
    req_val = 1'b0;
    tick();
    for (int i = 9; i >= 1; i--) begin
      mem_rsp_val = '0;
      resp(i % 2, i, 32'hB000 + i);
      tick();
      chk("t2_hold", {63'd0, rsp_val}, 64'd0);
    end
    mem_rsp_val = '0;
    resp(0, 0, 32'hB000);
    tick();
    mem_rsp_val = '0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_val", {63'd0, rsp_val}, 64'd1);
      chk("t2_ID", 64'(rsp_ID), 64'(i));
      tick();
    end
    chk("t2_drain", {63'd0, rsp_val}, 64'd0);

    // Fill all 16 entries, retire one, then check the wrapped tag.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req(4 * i, 100 + i, i);
      tick();
    end
    req(0, 99, 99);
    #1;
    chk("t3_full", {63'd0, req_ready}, 64'd0);
    req_val = 1'b0;
    tick();
    resp(0, 0, 32'hC0DE);
    tick();
    mem_rsp_val = '0;
    req(0, 17, 17);
    #1;
    chk("t3_no_bypass", {63'd0, req_ready}, 64'd0);
    tick();
    chk("t3_reopen", {63'd0, req_ready}, 64'd1);
    tick();
    chk("t3_wrap_tag", 64'(mem_req_ID[0 +: SW]), 64'd0);
    req_val = 1'b0;
    tick();

    // Channel 1 back-pressured for 5 cycles while channel 0 keeps moving.
    do_reset();
    req(4, 1, 1);
    tick();
    mem_req_ready = 2'b01;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) begin
        req(12, 2, 2);
        #1;
        chk("t4_stall", {63'd0, req_ready}, 64'd0);
      end else begin
        req(16 * j, 10 + j, j);
      end
      tick();
      chk("t4_hold_val", {63'd0, mem_req_val[1]}, 64'd1);
      chk("t4_hold_addr", 64'(mem_req_addr[AW +: AW]), 64'd4);
      chk("t4_hold_tag", 64'(mem_req_ID[SW +: SW]), 64'd0);
      if (j != 0) chk("t4_ch0_tag", 64'(mem_req_ID[0 +: SW]), 64'(j));
    end
    mem_req_ready = 2'b11;
    req(12, 2, 2);
    #1;
    chk("t4_release", {63'd0, req_ready}, 64'd1);
    tick();
    chk("t4_ch1_tag", 64'(mem_req_ID[SW +: SW]), 64'd5);
    chk("t4_ch1_addr", 64'(mem_req_addr[AW +: AW]), 64'd12);
    req_val = 1'b0;
    tick();

    // Head DONE while the client stalls for 8 cycles.
    do_reset();
    req(0, 7, 3);
    tick();
    req(4, 8, 4);
    tick();
    req_val = 1'b0;
    tick();
    resp(0, 0, 32'hDEAD0);
    resp(1, 1, 32'hBEEF1);
    tick();
    mem_rsp_val = '0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t5_hold_val", {63'd0, rsp_val}, 64'd1);
      chk("t5_hold_ID", 64'(rsp_ID), 64'd7);
      chk("t5_hold_data", 64'(rsp_data), 64'(32'hDEAD0));
      chk("t5_hold_param", 64'(rsp_param), 64'd3);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t5_second_ID", 64'(rsp_ID), 64'd8);
    chk("t5_second_data", 64'(rsp_data), 64'(32'hBEEF1));
    tick();
    chk("t5_drain", {63'd0, rsp_val}, 64'd0);

    // Spurious responses, then reset with a request still pending.
    do_reset();
    req(0, 0, 0);
    tick();
    req(4, 1, 1);
    tick();
    req_val = 1'b0;
    tick();
    chk("t6_err_clear", {63'd0, err_spurious}, 64'd0);
    resp(0, 3, 32'h33);
    tick();
    chk("t6_err_tag", {63'd0, err_spurious}, 64'd1);
    mem_rsp_val = '0;
    resp(0, 1, 32'h11);
    tick();
    chk("t6_err_wrong_ch", {63'd0, err_spurious}, 64'd1);
    mem_rsp_val = '0;
    resp(0, 0, 32'h55);
    tick();
    chk("t6_head_val", {63'd0, rsp_val}, 64'd1);
    mem_rsp_val = '0;
    rsp_ready = 1'b1;
    tick();
    chk("t6_tag1_open", {63'd0, rsp_val}, 64'd0);
    mem_req_ready = '0;
    req(8, 5, 5);
    tick();
    chk("t6_pending", {63'd0, mem_req_val[0]}, 64'd1);
    do_reset();

    // Randomized traffic with out-of-order memory responses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      req_val   = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_ID    = IW'($urandom);
      req_param = PW'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NCH; i++) begin
        mem_req_ready[i] = ($urandom_range(0, 9) < 7);
        used[i] = 1'b0;
      end
      mem_rsp_val = '0;
      for (int a = 0; a < NCH; a++) begin
        if (mem_out.size() > 0 && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, mem_out.size() - 1);
          c = mem_out[k] / DEPTH;
          t = mem_out[k] % DEPTH;
          if (!used[c]) begin
            used[c] = 1'b1;
            mem_out.delete(k);
            resp(c, t, $urandom);
          end
        end
      end
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
